// File: rtl/imm_field_stage.sv
// rtl/imm_field_stage.sv - IF/ID register with immediate-field extraction; IMM_STAGE_STATS_EN adds stall/flush counters
module imm_field_stage #(
  parameter int XLEN    = 32,
  parameter int FIELD_W = 21
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_inst,
  input  logic [XLEN-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_inst,
  output logic [XLEN-1:0]    out_pc,
  output logic [2:0]         imm_sel,
  output logic [FIELD_W-1:0] imm_field,
`ifdef IMM_STAGE_STATS_EN
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt,
`endif
  output logic [4:0]         imm_width
);

  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_I    = 3'd1;
  localparam logic [2:0] SEL_S    = 3'd2;
  localparam logic [2:0] SEL_B    = 3'd3;
  localparam logic [2:0] SEL_U    = 3'd4;
  localparam logic [2:0] SEL_J    = 3'd5;

  localparam logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013);

  logic        load;
  logic [2:0]  dec_sel;
  logic [20:0] dec_field;
  logic [4:0]  dec_width;

  // The stage can take a beat whenever its slot is empty, being drained, or being flushed
  assign in_ready = !out_valid | out_ready | flush;
  assign load     = in_valid & in_ready & !flush;

  // Classify the incoming opcode and gather the raw immediate bits right-aligned
  always_comb begin
    dec_sel   = SEL_NONE;
    dec_field = '0;
    dec_width = 5'd0;
    case (in_inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        dec_sel   = SEL_I;
        dec_field = {9'b0, in_inst[31:20]};
        dec_width = 5'd12;
      end
      7'b0100011: begin
        dec_sel   = SEL_S;
        dec_field = {9'b0, in_inst[31:25], in_inst[11:7]};
        dec_width = 5'd12;
      end
      7'b1100011: begin
        dec_sel   = SEL_B;
        dec_field = {8'b0, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
        dec_width = 5'd13;
      end
      7'b0110111, 7'b0010111: begin
        // Upper 20 bits only; the consumer applies the 12-bit left shift
        dec_sel   = SEL_U;
        dec_field = {1'b0, in_inst[31:12]};
        dec_width = 5'd20;
      end
      7'b1101111: begin
        dec_sel   = SEL_J;
        dec_field = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
        dec_width = 5'd21;
      end
      default: begin
        dec_sel   = SEL_NONE;
        dec_field = '0;
        dec_width = 5'd0;
      end
    endcase
  end

  // Entry register: reset beats flush, flush beats load, load beats drain
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_inst  <= NOP_INST;
      out_pc    <= '0;
      imm_sel   <= SEL_NONE;
      imm_field <= '0;
      imm_width <= 5'd0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_inst  <= in_inst;
      out_pc    <= in_pc;
      imm_sel   <= dec_sel;
      imm_field <= FIELD_W'(dec_field);
      imm_width <= dec_width;
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef IMM_STAGE_STATS_EN
  // Event counters: cycles stalled by decode, and cycles where a flush discarded live work
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid & !out_ready)
        stall_cnt <= stall_cnt + 32'd1;
      if (flush & (out_valid | in_valid))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_field_stage.sv
// tb/tb_imm_field_stage.sv - scoreboard bench for imm_field_stage against an ISA-level immediate model
module tb_imm_field_stage;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  sel;
    logic [20:0] field;
    logic [4:0]  width;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [2:0]  imm_sel;
  logic [20:0] imm_field;
  logic [4:0]  imm_width;
`ifdef IMM_STAGE_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] exp_stall = '0;
  logic [31:0] exp_flush = '0;
`endif

  int checks = 0;
  int errors = 0;
  bit running = 1'b0;
  entry_t q[$];
  entry_t pend;
  bit pend_v = 1'b0;

  imm_field_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .imm_sel(imm_sel), .imm_field(imm_field),
`ifdef IMM_STAGE_STATS_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .imm_width(imm_width)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: build the architectural immediate value, then keep the low bits
  function automatic entry_t ref_model(input logic [31:0] inst, input logic [31:0] pc);
    entry_t e;
    logic signed [31:0] s;
    logic [31:0] imm;
    int w;
    e.inst = inst;
    e.pc   = pc;
    imm    = 0;
    w      = 0;
    e.sel  = 3'd0;
    case (inst[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: begin
        e.sel = 3'd1; w = 12;
        s = $signed(inst) >>> 20;
        imm = s;
      end
      7'h23: begin
        e.sel = 3'd2; w = 12;
        s = $signed(inst) >>> 25;
        imm = (s << 5) | ((inst >> 7) & 32'h1F);
      end
      7'h63: begin
        e.sel = 3'd3; w = 13;
        imm = (inst[31] ? 32'hFFFF_F000 : 32'h0) | (((inst >> 7) & 32'h1) << 11)
            | (((inst >> 25) & 32'h3F) << 5) | (((inst >> 8) & 32'hF) << 1);
      end
      7'h37, 7'h17: begin
        e.sel = 3'd4; w = 20;
        imm = (inst & 32'hFFFF_F000) >> 12;
      end
      7'h6F: begin
        e.sel = 3'd5; w = 21;
        imm = (inst[31] ? 32'hFFF0_0000 : 32'h0) | (((inst >> 12) & 32'hFF) << 12)
            | (((inst >> 20) & 32'h1) << 11) | (((inst >> 21) & 32'h3FF) << 1);
      end
      default: begin
        e.sel = 3'd0; w = 0;
      end
    endcase
    imm     = imm & ((32'd1 << w) - 32'd1);
    e.field = imm[20:0];
    e.width = 5'(w);
    return e;
  endfunction

  // One driven cycle; the model decides whether the beat will be captured
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    @(negedge clk);
    if (pend_v) begin
      q.push_back(pend);
      pend_v = 1'b0;
    end
    rst       = 1'b0;
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    if (v && !fl && (q.size() == 0 || ordy)) begin
      pend   = ref_model(inst, pc);
      pend_v = 1'b1;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      flush    = 1'b0;
      q.delete();
      pend_v   = 1'b0;
`ifdef IMM_STAGE_STATS_EN
      exp_stall = '0;
      exp_flush = '0;
`endif
    end
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_inst", out_inst, 32'h0000_0013);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_imm_sel", imm_sel, 3'd0);
    chk("rst_imm_field", imm_field, 21'h0);
    chk("rst_imm_width", imm_width, 5'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    running = 1'b1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [10] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 9)];
    return r;
  endfunction

  // Monitor: compares the held entry with the scoreboard head and retires it on handshake or flush
  initial begin
    bit ev;
    forever begin
      @(negedge clk);
      #2;
      if (running && !rst) begin
        ev = (q.size() > 0);
        chk("out_valid", out_valid, ev);
        chk("in_ready", in_ready, !ev || out_ready || flush);
        if (ev) begin
          chk("out_inst", out_inst, q[0].inst);
          chk("out_pc", out_pc, q[0].pc);
          chk("imm_sel", imm_sel, q[0].sel);
          chk("imm_field", imm_field, q[0].field);
          chk("imm_width", imm_width, q[0].width);
        end
`ifdef IMM_STAGE_STATS_EN
        chk("stall_cnt", stall_cnt, exp_stall);
        chk("flush_cnt", flush_cnt, exp_flush);
        if (ev && !out_ready) exp_stall = exp_stall + 1;
        if (flush && (ev || in_valid)) exp_flush = exp_flush + 1;
`endif
        if (ev && (out_ready || flush)) void'(q.pop_front());
      end
    end
  end

  initial begin
    do_reset(2);
    // I-type, immediate -1
    step(1, 32'hFFF0_0093, 32'h100, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    // S-type held through a three-cycle stall while fetch keeps offering
    step(1, 32'hFE20_AE23, 32'h104, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 32'h0000_0013, 32'h108, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    // U then J back to back
    step(1, 32'h1234_52B7, 32'h200, 1, 0);
    step(1, 32'h0000_006F, 32'h204, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    // Flush with a held entry and an incoming beat
    step(1, 32'hFE00_0AE3, 32'h300, 0, 0);
    step(1, 32'h8000_006F, 32'h304, 0, 1);
    step(0, 32'h0, 32'h0, 1, 0);
    // Reset while stalled
    step(1, 32'h0010_0513, 32'h400, 0, 0);
    step(0, 32'h0, 32'h0, 0, 0);
    do_reset(1);
    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1);
      else step($urandom_range(0, 9) < 7, rand_inst(), $urandom,
                $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 4; i++) step(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    #3;
    chk("drain_empty", q.size(), 0);
    chk("final_out_valid", out_valid, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
